// File: rtl/per2axi_req_buffer.sv
// per2axi_req_buffer: FIFO-buffered peripheral-to-AXI request stage with per-direction outstanding limits.
// Define PER2AXI_ATOP_EN to map peripheral AMOs onto AXI atomics and exclusive accesses.
module per2axi_req_buffer #(
  parameter int NB_CORES        = 4,
  parameter int PER_ADDR_WIDTH  = 32,
  parameter int PER_ID_WIDTH    = 5,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int AXI_ID_WIDTH    = 3,
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0]          per_slave_add_i,
  input  logic                               per_slave_we_i,
  input  logic [5:0]                         per_slave_atop_i,
  input  logic [31:0]                        per_slave_wdata_i,
  input  logic [3:0]                         per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]            per_slave_id_i,
  output logic                               per_slave_gnt_o,
  input  logic [NB_CORES*AXI_USER_WIDTH-1:0] axi_axuser_i,
  output logic                               axi_master_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]          axi_master_aw_addr_o,
  output logic [2:0]                         axi_master_aw_prot_o,
  output logic [3:0]                         axi_master_aw_region_o,
  output logic [7:0]                         axi_master_aw_len_o,
  output logic [2:0]                         axi_master_aw_size_o,
  output logic [1:0]                         axi_master_aw_burst_o,
  output logic                               axi_master_aw_lock_o,
  output logic [5:0]                         axi_master_aw_atop_o,
  output logic [3:0]                         axi_master_aw_cache_o,
  output logic [3:0]                         axi_master_aw_qos_o,
  output logic [AXI_ID_WIDTH-1:0]            axi_master_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]          axi_master_aw_user_o,
  input  logic                               axi_master_aw_ready_i,
  output logic                               axi_master_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]          axi_master_ar_addr_o,
  output logic [2:0]                         axi_master_ar_prot_o,
  output logic [3:0]                         axi_master_ar_region_o,
  output logic [7:0]                         axi_master_ar_len_o,
  output logic [2:0]                         axi_master_ar_size_o,
  output logic [1:0]                         axi_master_ar_burst_o,
  output logic                               axi_master_ar_lock_o,
  output logic [3:0]                         axi_master_ar_cache_o,
  output logic [3:0]                         axi_master_ar_qos_o,
  output logic [AXI_ID_WIDTH-1:0]            axi_master_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]          axi_master_ar_user_o,
  input  logic                               axi_master_ar_ready_i,
  output logic                               axi_master_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]          axi_master_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]        axi_master_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0]          axi_master_w_user_o,
  output logic                               axi_master_w_last_o,
  input  logic                               axi_master_w_ready_i,
  input  logic                               b_done_i,
  input  logic                               r_done_i,
  output logic                               atop_req_o,
  output logic [AXI_ID_WIDTH-1:0]            atop_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]          atop_add_o,
  output logic                               trans_req_o,
  output logic [AXI_ID_WIDTH-1:0]            trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]          trans_add_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int NL = AXI_DATA_WIDTH / 32;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  typedef struct packed {
    logic [PER_ADDR_WIDTH-1:0] addr;
    logic                      wr;
    logic [5:0]                atop;
    logic [31:0]               wdata;
    logic [3:0]                be;
    logic [AXI_ID_WIDTH-1:0]   id;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t head, in_e;
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] cnt;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic aw_sent, w_sent, empty, full, push, pop;
  logic aw_hs, w_hs, ar_hs, aw_done, w_done, wr_ok, wr_dec, rd_dec;
  logic [AXI_ID_WIDTH-1:0] in_id;
  logic in_wr, aw_lock, ar_lock, inv;
  logic [5:0] x_atop;
  logic [31:0] wdata_eff;
  logic [PER_ADDR_WIDTH-1:0] lane;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;
  logic [AXI_USER_WIDTH-1:0] user;
  logic [2:0] size;
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(DEPTH);
  assign per_slave_gnt_o = per_slave_req_i && !full && !rst_i;
  assign push = per_slave_gnt_o;
  assign head = mem[rptr];
  always_comb begin
    in_id = '0;
    for (int i = 0; i < PER_ID_WIDTH; i++)
      if (per_slave_id_i[i]) in_id = AXI_ID_WIDTH'(i);
  end
`ifdef PER2AXI_ATOP_EN
  localparam logic [4:0] AMO_LR = 5'b00010, AMO_SC = 5'b00011, AMO_SWAP = 5'b00001,
    AMO_ADD = 5'b00000, AMO_XOR = 5'b00100, AMO_AND = 5'b01100, AMO_OR = 5'b01000,
    AMO_MIN = 5'b10000, AMO_MAX = 5'b10100, AMO_MINU = 5'b11000, AMO_MAXU = 5'b11100;
  // LR is the only AMO that travels on the read channel
  assign in_wr = per_slave_atop_i[5] ? per_slave_atop_i[4:0] != AMO_LR : !per_slave_we_i;
  always_comb begin
    x_atop = '0;
    inv = 1'b0;
    aw_lock = 1'b0;
    ar_lock = 1'b0;
    if (head.atop[5])
      case (head.atop[4:0])
        AMO_LR:   ar_lock = 1'b1;
        AMO_SC:   aw_lock = 1'b1;
        AMO_SWAP: x_atop = 6'b110000;
        AMO_ADD:  x_atop = 6'b100000;
        AMO_XOR:  x_atop = 6'b100010;
        AMO_OR:   x_atop = 6'b100011;
        AMO_MIN:  x_atop = 6'b100101;
        AMO_MAX:  x_atop = 6'b100100;
        AMO_MINU: x_atop = 6'b100111;
        AMO_MAXU: x_atop = 6'b100110;
        AMO_AND: begin
          x_atop = 6'b100001;
          inv = 1'b1;
        end
        default: ;
      endcase
  end
`else
  assign in_wr = !per_slave_we_i;
  assign x_atop = '0;
  assign inv = 1'b0;
  assign aw_lock = 1'b0;
  assign ar_lock = 1'b0;
`endif
  assign in_e = '{addr: per_slave_add_i, wr: in_wr, atop: per_slave_atop_i,
                  wdata: per_slave_wdata_i, be: per_slave_be_i, id: in_id};
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= in_e;
  // AW and W may each go first; the entry retires once both have handshaked
  assign wr_ok = wr_cnt < MAX_CNT;
  assign axi_master_aw_valid_o = !empty && head.wr && !aw_sent && (wr_ok || w_sent);
  assign axi_master_w_valid_o = !empty && head.wr && !w_sent && (aw_sent || wr_ok);
  assign axi_master_ar_valid_o = !empty && !head.wr && rd_cnt < MAX_CNT;
  assign aw_hs = axi_master_aw_valid_o && axi_master_aw_ready_i;
  assign w_hs = axi_master_w_valid_o && axi_master_w_ready_i;
  assign ar_hs = axi_master_ar_valid_o && axi_master_ar_ready_i;
  assign aw_done = aw_sent || aw_hs;
  assign w_done = w_sent || w_hs;
  assign pop = (aw_done && w_done) || ar_hs;
  assign wr_dec = b_done_i && wr_cnt != '0;
  assign rd_dec = r_done_i && rd_cnt != '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      aw_sent <= 1'b0;
      w_sent <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      aw_sent <= aw_done && !pop;
      w_sent <= w_done && !pop;
      wr_cnt <= wr_cnt + CW'(aw_hs) - CW'(wr_dec);
      rd_cnt <= rd_cnt + CW'(ar_hs) - CW'(rd_dec);
    end
  assign axi_addr = AXI_ADDR_WIDTH'(head.addr);
  assign user = AXI_USER_WIDTH'(axi_axuser_i >> (AXI_USER_WIDTH * head.id));
  assign size = (head.be == 4'(4'b0001 << head.addr[1:0])) ? 3'd0 :
                ((head.addr[1:0] == 2'b00 && head.be == 4'b0011) ||
                 (head.addr[1:0] == 2'b10 && head.be == 4'b1100)) ? 3'd1 : 3'd2;
  assign wdata_eff = inv ? ~head.wdata : head.wdata;
  assign lane = (head.addr >> 2) & PER_ADDR_WIDTH'(NL - 1);
  assign axi_master_w_data_o = AXI_DATA_WIDTH'(wdata_eff) << (lane << 5);
  assign axi_master_w_strb_o = (AXI_DATA_WIDTH/8)'(head.be) << (lane << 2);
  assign axi_master_w_user_o = user;
  assign axi_master_w_last_o = 1'b1;
  assign axi_master_aw_addr_o = axi_addr;
  assign axi_master_aw_size_o = size;
  assign axi_master_aw_lock_o = aw_lock;
  assign axi_master_aw_atop_o = x_atop;
  assign axi_master_aw_id_o = head.id;
  assign axi_master_aw_user_o = user;
  assign axi_master_ar_addr_o = axi_addr;
  assign axi_master_ar_size_o = size;
  assign axi_master_ar_lock_o = ar_lock;
  assign axi_master_ar_id_o = head.id;
  assign axi_master_ar_user_o = user;
  assign axi_master_aw_prot_o = '0;
  assign axi_master_aw_region_o = '0;
  assign axi_master_aw_len_o = '0;
  assign axi_master_aw_burst_o = 2'b00;
  assign axi_master_aw_cache_o = '0;
  assign axi_master_aw_qos_o = 4'b0001;
  assign axi_master_ar_prot_o = '0;
  assign axi_master_ar_region_o = '0;
  assign axi_master_ar_len_o = '0;
  assign axi_master_ar_burst_o = 2'b00;
  assign axi_master_ar_cache_o = '0;
  assign axi_master_ar_qos_o = 4'b0001;
  assign atop_req_o = aw_hs && x_atop != '0 && x_atop[5:3] != 3'b010;
  assign atop_id_o = head.id;
  assign atop_add_o = axi_addr;
  assign trans_req_o = ar_hs;
  assign trans_id_o = head.id;
  assign trans_add_o = axi_addr;
endmodule
